// File: rtl/pc_sequencer.sv
// Next-PC unit: PC register, next-PC selection, stall, exception redirect,
// target-alignment check and a circular return-address stack.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [2:0]                     select,
  input  logic [WIDTH-1:0]               branchAddr,
  input  logic [WIDTH-1:0]               jumpAddr,
  input  logic [WIDTH-1:0]               ReadData1,
  input  logic                           exc_req,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc4,
  output logic [WIDTH-1:0]               epc,
  output logic                           exc_taken,
  output logic                           misaligned,
  output logic                           illegal_sel,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

  localparam int PTRW = $clog2(RAS_DEPTH);
  localparam int CW   = $clog2(RAS_DEPTH+1);

  logic [WIDTH-1:0] pc_q, epc_q, nextPc_d, rasTop;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PTRW-1:0]  ptr_q;
  logic [CW-1:0]    rasCount_q;
  logic             excTaken_q, misaligned_q, illegalSel_q;
  logic             push_d, pop_d, illegal_d, misTarget_d;

  assign pc4    = pc_q + WIDTH'(4);
  assign rasTop = ras_q[ptr_q - PTRW'(1)];

  always_comb begin
    nextPc_d  = pc4;
    push_d    = 1'b0;
    pop_d     = 1'b0;
    illegal_d = 1'b0;
    case (select)
      3'b000: nextPc_d = pc4;
      3'b001: nextPc_d = branchAddr;
      3'b010: nextPc_d = jumpAddr;
      3'b011: nextPc_d = ReadData1;
      3'b100: begin
        nextPc_d = jumpAddr;
        push_d   = 1'b1;
      end
      3'b101: begin
        // An empty stack falls back to the register target without popping.
        if (rasCount_q != '0) begin
          nextPc_d = rasTop;
          pop_d    = 1'b1;
        end else begin
          nextPc_d = ReadData1;
        end
      end
      default: illegal_d = 1'b1;
    endcase
    misTarget_d = (nextPc_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      excTaken_q   <= 1'b0;
      misaligned_q <= 1'b0;
      illegalSel_q <= 1'b0;
      ptr_q        <= '0;
      rasCount_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      excTaken_q   <= 1'b0;
      misaligned_q <= 1'b0;
      illegalSel_q <= 1'b0;
      if (!stall) begin
        illegalSel_q <= illegal_d;
        if (exc_req) begin
          pc_q       <= EXC_VECTOR;
          epc_q      <= pc_q;
          excTaken_q <= 1'b1;
        end else if (misTarget_d) begin
          pc_q         <= EXC_VECTOR;
          epc_q        <= nextPc_d;
          excTaken_q   <= 1'b1;
          misaligned_q <= 1'b1;
        end else begin
          pc_q <= nextPc_d;
          // Overflow overwrites the oldest entry; the count just saturates.
          if (push_d) begin
            ras_q[ptr_q] <= pc4;
            ptr_q        <= ptr_q + PTRW'(1);
            if (rasCount_q != CW'(RAS_DEPTH)) rasCount_q <= rasCount_q + CW'(1);
          end else if (pop_d) begin
            ptr_q      <= ptr_q - PTRW'(1);
            rasCount_q <= rasCount_q - CW'(1);
          end
        end
      end
    end
  end

  assign pc          = pc_q;
  assign epc         = epc_q;
  assign exc_taken   = excTaken_q;
  assign misaligned  = misaligned_q;
  assign illegal_sel = illegalSel_q;
  assign ras_count   = rasCount_q;

endmodule
